// File: rtl/cache_mem_arbiter.sv
// Shares one 128-bit memory/L2 port between the LC-3b I-cache and D-cache.
// One owner at a time, request latched at grant, round-robin on simultaneous requests.
module cache_mem_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_read,
  input  logic [15:0]  i_address,
  output logic         i_resp,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [15:0]  d_address,
  input  logic [127:0] d_wdata,
  output logic         d_resp,
  output logic [127:0] rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int WORD_W = 16;
  localparam int LINE_W = 128;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
  typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} grant_t;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic              write;
    logic [LINE_W-1:0] wdata;
  } req_t;

  state_t state, state_nxt;
  grant_t last_grant;
  req_t   lat;
  logic   i_req, d_req, grant_i, grant_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // On a tie the port goes to whoever did not win last time.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (i_req && d_req) begin
        grant_d = (last_grant == GNT_I);
        grant_i = (last_grant == GNT_D);
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d)      state_nxt = SERVE_D;
        else if (grant_i) state_nxt = SERVE_I;
      end
      SERVE_I, SERVE_D: if (pmem_resp) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write line is only captured for D writes; otherwise it holds its last value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat        <= '0;
      last_grant <= GNT_I;
    end else if (grant_d) begin
      lat.addr   <= d_address;
      lat.write  <= d_write;
      if (d_write) lat.wdata <= d_wdata;
      last_grant <= GNT_D;
    end else if (grant_i) begin
      lat.addr   <= i_address;
      lat.write  <= 1'b0;
      last_grant <= GNT_I;
    end
  end

  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state)
      SERVE_I: begin
        pmem_read = 1'b1;
        i_resp    = pmem_resp;
      end
      SERVE_D: begin
        pmem_read  = ~lat.write;
        pmem_write = lat.write;
        d_resp     = pmem_resp;
      end
      default: ;
    endcase
  end

  assign pmem_address = lat.addr;
  assign pmem_wdata   = lat.wdata;
  assign rdata        = pmem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: reset, round-robin, latching, zero-wait and mid-service reset.
module tb_cache_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_read;
  logic [15:0]  i_address;
  logic         i_resp;
  logic         d_read, d_write;
  logic [15:0]  d_address;
  logic [127:0] d_wdata;
  logic         d_resp;
  logic [127:0] rdata;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] BEEF = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  localparam logic [127:0] A5   = {16{8'hA5}};
  localparam logic [127:0] L1   = {8{16'h1111}};
  localparam logic [127:0] L2   = {8{16'h2222}};

  cache_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address),
    .d_wdata(d_wdata), .d_resp(d_resp), .rdata(rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %b exp %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic chk_strobes(input string tag, input logic rd, input logic wr);
    chk1({tag, "_rd"}, pmem_read, rd);
    chk1({tag, "_wr"}, pmem_write, wr);
  endtask

  task automatic chk_resps(input string tag, input logic ir, input logic dr);
    chk1({tag, "_iresp"}, i_resp, ir);
    chk1({tag, "_dresp"}, d_resp, dr);
  endtask

  initial begin
    rst_n = 1'b0; i_read = 1'b1; i_address = 16'h2000;
    d_read = 1'b0; d_write = 1'b1; d_address = 16'h4000; d_wdata = BEEF;
    pmem_rdata = 128'h0123; pmem_resp = 1'b0;

    // Reset held two cycles with both requesting
    step(); step();
    chk_strobes("rst", 1'b0, 1'b0);
    chk_resps("rst", 1'b0, 1'b0);
    chk16("rst_addr", pmem_address, 16'h0000);
    chk128("rst_wdata", pmem_wdata, 128'h0);
    chk128("rst_rdata", rdata, 128'h0123);

    // First tie after reset goes to D
    rst_n = 1'b1;
    step();
    chk_strobes("g1_d", 1'b0, 1'b1);
    chk16("g1_addr", pmem_address, 16'h4000);
    chk128("g1_wdata", pmem_wdata, BEEF);
    chk_resps("g1_wait", 1'b0, 1'b0);

    // Address change after grant must not leak through
    d_address = 16'hFFFF;
    step();
    chk16("g1_hold_addr", pmem_address, 16'h4000);
    chk_strobes("g1_hold", 1'b0, 1'b1);
    pmem_resp = 1'b1; #1;
    chk_resps("g1_resp", 1'b0, 1'b1);
    step();
    pmem_resp = 1'b0; #1;
    chk_strobes("g1_idle", 1'b0, 1'b0);
    chk_resps("g1_idle", 1'b0, 1'b0);
    chk16("g1_idle_addr", pmem_address, 16'h4000);
    d_address = 16'h4000;

    // Second tie goes to I; zero-wait response
    step();
    chk_strobes("g2_i", 1'b1, 1'b0);
    chk16("g2_addr", pmem_address, 16'h2000);
    chk128("g2_wdata_hold", pmem_wdata, BEEF);
    pmem_resp = 1'b1; pmem_rdata = L2; #1;
    chk_resps("g2_resp", 1'b1, 1'b0);
    chk128("g2_rdata", rdata, L2);
    step();
    pmem_resp = 1'b0; #1;
    chk_strobes("g2_idle", 1'b0, 1'b0);

    // Third and fourth grants alternate D then I
    step();
    chk_strobes("g3_d", 1'b0, 1'b1);
    chk16("g3_addr", pmem_address, 16'h4000);
    pmem_resp = 1'b1; #1;
    chk_resps("g3_resp", 1'b0, 1'b1);
    step();
    pmem_resp = 1'b0;
    step();
    chk_strobes("g4_i", 1'b1, 1'b0);
    pmem_resp = 1'b1; #1;
    chk_resps("g4_resp", 1'b1, 1'b0);
    step();
    pmem_resp = 1'b0; i_read = 1'b0; #1;
    chk_resps("g4_idle", 1'b0, 1'b0);

    // Reset in SERVE_D with pmem_write high
    d_wdata = L1;
    step();
    chk_strobes("sd_w", 1'b0, 1'b1);
    chk128("sd_wdata", pmem_wdata, L1);
    rst_n = 1'b0; d_write = 1'b0;
    step();
    chk_strobes("mid_rst", 1'b0, 1'b0);
    chk16("mid_rst_addr", pmem_address, 16'h0000);
    chk128("mid_rst_wdata", pmem_wdata, 128'h0);
    rst_n = 1'b1;

    // Lone I read, response after 3 wait cycles; request dropped mid-service
    i_read = 1'b1; i_address = 16'h1230; pmem_rdata = A5;
    step();
    chk_strobes("li_c1", 1'b1, 1'b0);
    chk16("li_addr", pmem_address, 16'h1230);
    chk_resps("li_c1", 1'b0, 1'b0);
    i_read = 1'b0;
    step();
    chk_strobes("li_c2", 1'b1, 1'b0);
    step();
    chk_strobes("li_c3", 1'b1, 1'b0);
    chk_resps("li_c3", 1'b0, 1'b0);
    step();
    chk_strobes("li_c4", 1'b1, 1'b0);
    pmem_resp = 1'b1; #1;
    chk_resps("li_c4", 1'b1, 1'b0);
    chk128("li_rdata", rdata, A5);
    step();
    pmem_resp = 1'b0; #1;
    chk_strobes("li_idle", 1'b0, 1'b0);
    chk_resps("li_idle", 1'b0, 1'b0);

    // d_read and d_write together act as a write
    d_read = 1'b1; d_write = 1'b1; d_address = 16'h0440; d_wdata = L1;
    step();
    chk_strobes("rw_both", 1'b0, 1'b1);
    chk128("rw_wdata", pmem_wdata, L1);
    pmem_resp = 1'b1; #1;
    chk_resps("rw_resp", 1'b0, 1'b1);
    step();
    pmem_resp = 1'b0; d_write = 1'b0; d_wdata = L2; d_address = 16'h0880;

    // D read does not capture d_wdata
    step();
    chk_strobes("dr", 1'b1, 1'b0);
    chk16("dr_addr", pmem_address, 16'h0880);
    chk128("dr_wdata_hold", pmem_wdata, L1);
    pmem_resp = 1'b1; #1;
    chk_resps("dr_resp", 1'b0, 1'b1);
    step();
    pmem_resp = 1'b0; d_read = 1'b0;
    step();
    chk_strobes("end_idle", 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Two-port arbiter that shares the single 128-bit (lc3b_datbus) physical-memory / L2 port between the instruction cache and the data cache of the pipelined LC-3b. It grants one requester at a time, latches that requester's address, operation and write line, drives the downstream port until `pmem_resp`, and routes the response back to the owner. Ties are resolved round-robin so neither cache starves.

## Interface
Parameters:
- none; widths fixed by lc3b_types (lc3b_word address, lc3b_datbus line).

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on rising `clk`.
- `i_read`  in  1  I-cache line read request; held until `i_resp`.
- `i_address`  in  16  I-cache line address.
- `i_resp`  out  1  one-cycle completion to I-cache.
- `d_read`, `d_write`  in  1 each  D-cache read / writeback request; mutually exclusive, held until `d_resp`.
- `d_address`  in  16  D-cache line address.
- `d_wdata`  in  128  D-cache writeback line.
- `d_resp`  out  1  one-cycle completion to D-cache.
- `rdata`  out  128  `pmem_rdata` broadcast to both caches; valid only with the owner's resp.
- `pmem_read`, `pmem_write`  out  1 each  downstream strobes.
- `pmem_address`  out  16  latched owner address.
- `pmem_wdata`  out  128  latched write line.
- `pmem_rdata`  in  128  downstream read line.
- `pmem_resp`  in  1  downstream completion, one cycle.

## Operation
- States: IDLE, SERVE_I, SERVE_D. Register `last_grant` (I or D), reset to I.
- IDLE: i_req = `i_read`; d_req = `d_read|d_write`.
  - only i_req -> SERVE_I; only d_req -> SERVE_D.
  - both -> grant the port not equal to `last_grant` (first tie after reset goes to D).
  - on grant: latch address, op (read/write), and `d_wdata` (D writes only) into `lat_*` registers; set `last_grant`.
- SERVE_x: `pmem_read`/`pmem_write` = latched op, `pmem_address`/`pmem_wdata` = latched values; requester inputs ignored.
  - on `pmem_resp`: assert owner's resp (combinational, same cycle), next state IDLE.
- `rdata` = `pmem_rdata` always; the non-owner's resp is never asserted.
- IDLE drives all pmem strobes low; `pmem_address`/`pmem_wdata` hold the last latched values.
- Requester dropping its request mid-service: transaction is still completed with latched values; the resp pulse is still issued.
- `d_read` and `d_write` both high: treated as write.
- Reset (any state, including mid-transaction): next cycle state IDLE, `last_grant`=I, latches cleared to 0, all strobes and resps 0; the outstanding downstream transaction is abandoned (pmem is reset together with the arbiter).

## Timing
- Reset values: `pmem_read`=0, `pmem_write`=0, `pmem_address`=0, `pmem_wdata`=0, `i_resp`=0, `d_resp`=0; `rdata` follows `pmem_rdata`.
- Request sampled high in IDLE at edge N -> strobes high from cycle N+1.
- Strobes stay high through the cycle `pmem_resp` is high; low the following cycle (IDLE).
- Resp to requester: 0 cycles after `pmem_resp` (same cycle), exactly one cycle wide.
- Minimum one IDLE cycle between consecutive transactions; back-to-back cost = pmem latency + 1.
- Maximum wait for a continuously asserted request: one full transaction of the other requester.

## Test plan
- Reset: hold `rst_n`=0 two cycles with both caches requesting -> all strobes/resps 0; release -> D granted first (tie, last_grant=I).
- Lone I read at 16'h1230, pmem resp after 3 cycles with line 128'hA5..A5 -> `pmem_read` high cycles 1-4, `i_resp` one pulse with `rdata`=A5..A5, `d_resp` stays 0.
- Simultaneous and continuous I read + D write (addr 16'h4000, data 128'hDEAD_BEEF...) -> grants alternate D, I, D, I; each owner sees exactly one resp per transaction; `pmem_wdata` matches latched D line.
- D changes `d_address` to 16'hFFFF one cycle after grant -> `pmem_address` stays at latched value until `pmem_resp`.
- `rst_n` asserted while in SERVE_D with `pmem_write` high -> next cycle strobes 0, state IDLE; a subsequent lone I request is served normally.
- `pmem_resp` with zero wait (high the first strobe cycle) -> resp same cycle, IDLE next cycle, new grant the cycle after.
